// File: rtl/btn_scan_sword.sv
// rtl/btn_scan_sword.sv - 5x4 key matrix scanner with per-key debounce and 4-entry press-event FIFO
module btn_scan_sword #(
  parameter int CLK_FREQ         = 10,
  parameter int SCAN_INTERVAL_US = 1000,
  parameter int DEBOUNCE_SCANS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  btn_x,
  input  logic [3:0]  btn_y,
  output logic [19:0] keys,
  output logic        key_valid,
  output logic [4:0]  key_code,
  input  logic        key_ack,
  output logic        overflow
);

  // Dwell length in cycles; the counter only has to reach DWELL-1.
  localparam int DWELL = CLK_FREQ * SCAN_INTERVAL_US;
  localparam int DW_W  = $clog2(DWELL);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0] DW_ONE     = DW_W'(1);
  localparam logic [3:0]      DEB_N      = 4'(DEBOUNCE_SCANS);

  typedef enum logic {
    ST_DWELL  = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  // Synchronizer holds the inverted row sense, so 1 = pressed and reset (0) = released.
  logic [3:0]       y_meta_q, y_meta_d;
  logic [3:0]       y_sync_q, y_sync_d;

  // Scan state.
  state_t           state_q, state_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [2:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_sample_q, row_sample_d;
  logic [4:0]       btn_x_q, btn_x_d;

  // Debounce state.
  logic [19:0]      keys_q, keys_d;
  logic [19:0][2:0] cnt_q, cnt_d;

  // Event FIFO.
  logic [3:0][4:0]  mem_q, mem_d;
  logic [1:0]       wr_q, wr_d;
  logic [1:0]       rd_q, rd_d;
  logic [2:0]       count_q, count_d;
  logic [4:0]       key_code_q, key_code_d;

  // Scan-to-FIFO handshake and helpers.
  logic             push_req;
  logic [4:0]       push_code;
  logic [4:0]       key_idx;
  logic             sample;
  logic [3:0]       cnt_inc;
  logic             pop;
  logic             full;
  logic             do_push;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_comb begin
    y_meta_d = ~btn_y;
    y_sync_d = y_meta_q;
  end

  // Scan FSM: dwell on a column, then debounce its four keys one row per cycle.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    col_d        = col_q;
    row_d        = row_q;
    row_sample_d = row_sample_q;
    btn_x_d      = btn_x_q;
    keys_d       = keys_q;
    cnt_d        = cnt_q;
    push_req     = 1'b0;
    push_code    = 5'd0;
    // col*4+row is simply the concatenation of column and row.
    key_idx      = {col_q, row_q};
    sample       = row_sample_q[row_q];
    cnt_inc      = {1'b0, cnt_q[key_idx]} + 4'd1;

    case (state_q)
      ST_DWELL: begin
        if (dwell_q == DWELL_LAST) begin
          row_sample_d = y_sync_q;
          row_d        = 2'd0;
          state_d      = ST_UPDATE;
        end else begin
          dwell_d = dwell_q + DW_ONE;
        end
      end

      ST_UPDATE: begin
        if (sample == keys_q[key_idx]) begin
          cnt_d[key_idx] = 3'd0;
        end else if (cnt_inc < DEB_N) begin
          cnt_d[key_idx] = cnt_inc[2:0];
        end else begin
          keys_d[key_idx] = sample;
          cnt_d[key_idx]  = 3'd0;
          // Only presses are reported; releases just clear the key bit.
          if (sample) begin
            push_req  = 1'b1;
            push_code = key_idx;
          end
        end

        if (row_q == 2'd3) begin
          col_d   = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
          btn_x_d = ~(5'b00001 << col_d);
          dwell_d = '0;
          row_d   = 2'd0;
          state_d = ST_DWELL;
        end else begin
          row_d = row_q + 2'd1;
        end
      end

      default: begin
        state_d = ST_DWELL;
      end
    endcase
  end

  // Event FIFO: one push (from the scanner) and one pop (key_ack) per cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;
    pop      = key_ack && (count_q != 3'd0);
    full     = (count_q == 3'd4);
    // When full, a same-cycle pop frees the slot the push reuses.
    do_push  = push_req && (!full || pop);
    overflow = push_req && full && !pop;

    if (do_push) begin
      mem_d[wr_q] = push_code;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) begin
      rd_d = rd_q + 2'd1;
    end

    case ({do_push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    key_code_d = (count_d != 3'd0) ? mem_d[rd_d] : 5'd0;
  end

  // State registers; reset aborts any scan in progress and restarts at column 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_meta_q     <= 4'd0;
      y_sync_q     <= 4'd0;
      state_q      <= ST_DWELL;
      dwell_q      <= '0;
      col_q        <= 3'd0;
      row_q        <= 2'd0;
      row_sample_q <= 4'd0;
      btn_x_q      <= 5'b11110;
      keys_q       <= 20'd0;
      cnt_q        <= '0;
      mem_q        <= '0;
      wr_q         <= 2'd0;
      rd_q         <= 2'd0;
      count_q      <= 3'd0;
      key_code_q   <= 5'd0;
    end else begin
      y_meta_q     <= y_meta_d;
      y_sync_q     <= y_sync_d;
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_sample_q <= row_sample_d;
      btn_x_q      <= btn_x_d;
      keys_q       <= keys_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      key_code_q   <= key_code_d;
    end
  end

  assign btn_x     = btn_x_q;
  assign keys      = keys_q;
  assign key_valid = (count_q != 3'd0);
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_btn_scan_sword.sv
// tb/tb_btn_scan_sword.sv - scoreboard bench for the key matrix scanner
module tb_btn_scan_sword;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn_x;
  logic [3:0]  btn_y;
  logic [19:0] keys;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ack = 1'b0;
  logic        overflow;

  logic [19:0] pressed = 20'd0;
  logic        ack_en  = 1'b0;
  int          n_cmp   = 0;
  int          n_fail  = 0;
  int          ovf_cnt = 0;
  logic [4:0]  exp_q[$];

  btn_scan_sword #(
    .CLK_FREQ(10),
    .SCAN_INTERVAL_US(1),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_x(btn_x),
    .btn_y(btn_y),
    .keys(keys),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ack(key_ack),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    btn_y = 4'hF;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 4; r++)
        if (!btn_x[c] && pressed[c*4+r]) btn_y[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] col_mask(input int c);
    logic [4:0] m;
    m = 5'b00001 << c;
    return ~m;
  endfunction

  // Returns at the first negedge after column c stops being driven.
  task automatic wait_leave_col(input int c);
    int n;
    n = 0;
    while (btn_x != col_mask(c) && n < 200) begin @(negedge clk); n++; end
    while (btn_x == col_mask(c) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_leave_col%0d: timeout after %0d cycles", c, n);
    end
  endtask

  // Cycles the scanner stays on column c, starting from the current negedge.
  task automatic measure_col(input int c, input string name);
    int n;
    n = 0;
    while (btn_x == col_mask(c) && n < 100) begin @(negedge clk); n++; end
    check(name, 32'(n), 32'd14);
  endtask

  // Monitor: acks whatever the DUT presents and checks it against the scoreboard.
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (ack_en && key_valid && !rst) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got code %0d, expected no event", key_code);
      end else begin
        check("event_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
      key_ack = 1'b1;
    end else begin
      key_ack = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ovf0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_btn_x", 32'(btn_x), 32'h1E);
    check("rst_keys", 32'(keys), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);

    // Column timing: DWELL + 4 = 14 cycles per column, starting at column 0
    rst = 1'b0;
    measure_col(0, "col0_cycles");
    check("col1_drive", 32'(btn_x), 32'h1D);
    measure_col(1, "col1_cycles");

    // Hold key 9: flips on the second col-2 pass, one event, acked
    ack_en = 1'b1;
    wait_leave_col(4);
    exp_q.push_back(5'd9);
    pressed[9] = 1'b1;
    wait_leave_col(2);
    check("k9_after_pass1", 32'(keys[9]), 32'h0);
    wait_leave_col(2);
    check("k9_after_pass2", 32'(keys[9]), 32'h1);
    repeat (3) @(negedge clk);
    check("k9_acked_valid", 32'(key_valid), 32'h0);

    // Release key 9: clears after two scans, no event
    pressed[9] = 1'b0;
    wait_leave_col(2);
    check("k9_rel_pass1", 32'(keys[9]), 32'h1);
    wait_leave_col(2);
    check("k9_rel_pass2", 32'(keys[9]), 32'h0);
    check("k9_rel_no_event", 32'(key_valid), 32'h0);

    // One-scan presses separated by a release never flip the key
    for (int i = 0; i < 2; i++) begin
      pressed[9] = 1'b1;
      wait_leave_col(2);
      check("glitch_press", 32'(keys[9]), 32'h0);
      pressed[9] = 1'b0;
      wait_leave_col(2);
      check("glitch_release", 32'(keys[9]), 32'h0);
    end

    // Whole column 3 pressed: events 12,13,14,15 in row order
    for (int k = 12; k < 16; k++) exp_q.push_back(5'(k));
    pressed[15:12] = 4'hF;
    wait_leave_col(3);
    check("col3_pass1", 32'(keys[15:12]), 32'h0);
    wait_leave_col(3);
    repeat (5) @(negedge clk);
    check("col3_pass2", 32'(keys[15:12]), 32'hF);
    check("col3_drained", 32'(exp_q.size()), 32'd0);
    pressed[15:12] = 4'h0;
    wait_leave_col(3);
    wait_leave_col(3);
    check("col3_released", 32'(keys), 32'h0);

    // Five presses without ack: FIFO holds 0,4,8,12 and key 16 overflows
    ack_en = 1'b0;
    wait_leave_col(4);
    pressed = 20'h11111;
    ovf0 = ovf_cnt;
    wait_leave_col(4);
    check("ovf_pass1_keys", 32'(keys), 32'h0);
    wait_leave_col(4);
    repeat (2) @(negedge clk);
    check("ovf_keys", 32'(keys), 32'h11111);
    check("ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
    check("ovf_valid", 32'(key_valid), 32'h1);
    check("ovf_head", 32'(key_code), 32'h0);
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd4);
    exp_q.push_back(5'd8);
    exp_q.push_back(5'd12);
    pressed = 20'd0;
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_empty", 32'(key_valid), 32'h0);
    wait_leave_col(4);
    wait_leave_col(4);
    check("ovf_released", 32'(keys), 32'h0);

    // Asynchronous reset during UPDATE row 2 of column 2
    ack_en = 1'b0;
    pressed[9] = 1'b1;
    wait_leave_col(2);
    wait_leave_col(2);
    wait_leave_col(1);
    repeat (12) @(negedge clk);
    check("pre_rst_valid", 32'(key_valid), 32'h1);
    check("pre_rst_keys", 32'(keys), 32'h200);
    rst = 1'b1;
    #1;
    check("async_btn_x", 32'(btn_x), 32'h1E);
    check("async_keys", 32'(keys), 32'h0);
    check("async_valid", 32'(key_valid), 32'h0);
    check("async_code", 32'(key_code), 32'h0);
    pressed[9] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    measure_col(0, "resume_col0_cycles");
    check("resume_col1_drive", 32'(btn_x), 32'h1D);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
